// File: rtl/lcompressor_pkg.sv
// lcompressor_pkg: scheduler state encoding, default sample width and a ceil-log2 helper for derived widths
package lcompressor_pkg;
  localparam int DEF_W = 8;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/lcompressor_rr_arb.sv
// lcompressor_rr_arb: combinational round-robin arbiter; req in, ptr in, one-hot gnt and its index idx out
module lcompressor_rr_arb
  import lcompressor_pkg::*;
#(
  parameter int NCH = 4,
  parameter int PW = clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [PW-1:0]  idx
);
  logic [PW:0]   s;
  logic [PW-1:0] k;
  always_comb begin
    gnt = '0;
    idx = '0;
    s = '0;
    k = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      s = {1'b0, ptr} + (PW+1)'(i);
      k = s >= (PW+1)'(NCH) ? PW'(s - (PW+1)'(NCH)) : s[PW-1:0];
      if (req[k]) begin
        gnt = '0;
        gnt[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/lcompressor_sched.sv
// lcompressor_sched: round-robin share of one LAT-cycle engine among NCH channels; i_valid/i_data/o_ready in, o_comp_* to engine, i_comp_data back, o_valid/o_data per channel, o_busy
module lcompressor_sched
  import lcompressor_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W = DEF_W,
  parameter int LAT = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [NCH-1:0]   i_valid,
  input  logic [NCH*W-1:0] i_data,
  output logic [NCH-1:0]   o_ready,
  output logic [W-1:0]     o_comp_data,
  output logic             o_comp_valid,
  input  logic [W-1:0]     i_comp_data,
  output logic [NCH-1:0]   o_valid,
  output logic [NCH*W-1:0] o_data,
  output logic             o_busy
);
  localparam int PW = clog2(NCH);
  localparam int CW = clog2(LAT + 3);
  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [NCH-1:0] gnt;
  logic [LAT:0]  tag_v;
  logic [PW-1:0] tag_c [LAT+1];
  logic [CW-1:0] inflight;
  logic          grant;
  logic          retire;
  lcompressor_rr_arb #(.NCH(NCH)) u_arb (.req(i_valid), .ptr(ptr), .gnt(gnt), .idx(gidx));
  assign o_ready = state == S_RUN && !i_reset ? gnt : '0;
  assign grant = |o_ready;
  assign retire = tag_v[LAT];
  assign o_busy = state != S_IDLE || inflight != '0;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      ptr <= '0;
      o_comp_data <= '0;
      o_comp_valid <= 1'b0;
      o_valid <= '0;
      o_data <= '0;
      tag_v <= '0;
      inflight <= '0;
      for (int i = 0; i <= LAT; i++) tag_c[i] <= '0;
    end else begin
      o_comp_valid <= grant;
      if (grant) begin
        o_comp_data <= i_data[gidx*W +: W];
        ptr <= gidx == PW'(NCH - 1) ? '0 : gidx + 1'b1;
      end
      tag_v <= {tag_v[LAT-1:0], grant};
      tag_c[0] <= gidx;
      for (int i = 1; i <= LAT; i++) tag_c[i] <= tag_c[i-1];
      o_valid <= '0;
      if (retire) begin
        o_valid[tag_c[LAT]] <= 1'b1;
        o_data[tag_c[LAT]*W +: W] <= i_comp_data;
      end
      inflight <= inflight + CW'(grant) - CW'(retire);
      state <= state == S_IDLE ? (i_enable && |i_valid ? S_RUN : S_IDLE) :
               state == S_RUN  ? (i_enable ? S_RUN : S_DRAIN) :
               i_enable ? S_RUN : inflight == '0 ? S_IDLE : S_DRAIN;
    end
  end
endmodule

// File: tb/tb_lcompressor_sched.sv
// tb_lcompressor_sched: randomized scoreboard bench with an XOR-5A engine model and a round-robin reference
module tb_lcompressor_sched;
  localparam int NCH = 4;
  localparam int W = 8;
  localparam int LAT = 2;
  localparam int IDLE = 0;
  localparam int RUN = 1;
  localparam int DRAIN = 2;
  typedef struct { logic [W-1:0] d; int due; } exp_t;
  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_enable = 1'b0;
  logic [NCH-1:0] i_valid = '0;
  logic [NCH*W-1:0] i_data = '0;
  logic [W-1:0] i_comp_data = '0;
  logic [NCH-1:0] o_ready;
  logic [W-1:0] o_comp_data;
  logic o_comp_valid;
  logic [NCH-1:0] o_valid;
  logic [NCH*W-1:0] o_data;
  logic o_busy;
  exp_t expq [NCH][$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int m_state = IDLE;
  int m_ptr = 0;
  int gcyc[$];
  logic exp_cv = 1'b0;
  logic [W-1:0] exp_cd = '0;
  logic [W-1:0] hist[$];
  logic [NCH-1:0] last_hs = '0;
  bit clr = 1'b0;
  bit zchk = 1'b0;
  always #5 clk = ~clk;
  lcompressor_sched #(.NCH(NCH), .W(W), .LAT(LAT)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .o_comp_data(o_comp_data), .o_comp_valid(o_comp_valid),
    .i_comp_data(i_comp_data), .o_valid(o_valid), .o_data(o_data), .o_busy(o_busy)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask
  function automatic int rr(input logic [NCH-1:0] v, input int p);
    logic [NCH-1:0] s;
    for (int i = 0; i < NCH; i++) begin
      s = v >> ((p + i) % NCH);
      if (s[0]) return (p + i) % NCH;
    end
    return -1;
  endfunction
  function automatic int pending();
    int n;
    n = 0;
    for (int k = 0; k < NCH; k++) n += expq[k].size();
    return n;
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      logic [NCH-1:0] v;
      logic [NCH*W-1:0] dd;
      exp_t e;
      v = o_valid >> k;
      dd = o_data >> (k*W);
      if (v[0]) begin
        if (expq[k].size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_o_valid at cycle %0d: channel %0d pulsed with data %0h, none expected", cyc, k, dd[W-1:0]);
        end else begin
          e = expq[k].pop_front();
          chk($sformatf("result_data_ch%0d", k), 32'(dd[W-1:0]), 32'(e.d));
          chk($sformatf("result_cycle_ch%0d", k), 32'(cyc), 32'(e.due));
        end
      end
    end
  end
  task automatic tick(input bit rst, input bit en, input logic [NCH-1:0] act, input int pct, input bit wd, input int dval);
    int inf;
    int g;
    logic [NCH-1:0] sa, sc, sh, nv, exp_rdy;
    logic [NCH*W-1:0] dd;
    @(posedge clk);
    #1;
    cyc++;
    hist.push_back(o_comp_data ^ 8'h5A);
    if (hist.size() > LAT + 1) void'(hist.pop_front());
    i_comp_data = hist.size() == LAT + 1 ? hist[0] : '0;
    if (clr) begin
      for (int k = 0; k < NCH; k++) expq[k].delete();
      clr = 1'b0;
    end
    nv = '0;
    for (int k = 0; k < NCH; k++) begin
      sa = act >> k;
      sc = i_valid >> k;
      sh = last_hs >> k;
      if (!sa[0]) begin
      end else if (sc[0] && !sh[0]) begin
        if (!(wd && $urandom_range(0, 3) == 0)) nv |= NCH'(1) << k;
      end else if ($urandom_range(0, 99) < pct) begin
        nv |= NCH'(1) << k;
        i_data[k*W +: W] = dval < 0 ? W'($urandom) : W'(dval);
      end
    end
    i_valid = nv;
    i_reset = rst;
    i_enable = en;
    @(negedge clk);
    while (gcyc.size() > 0 && gcyc[0] + LAT + 1 < cyc) void'(gcyc.pop_front());
    inf = 0;
    foreach (gcyc[j]) if (gcyc[j] < cyc && cyc <= gcyc[j] + LAT + 1) inf++;
    g = (rst || m_state != RUN) ? -1 : rr(i_valid, m_ptr);
    exp_rdy = g < 0 ? '0 : NCH'(1) << g;
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    chk("o_comp_valid", 32'(o_comp_valid), 32'(exp_cv));
    if (exp_cv) chk("o_comp_data", 32'(o_comp_data), 32'(exp_cd));
    chk("o_busy", 32'(o_busy), 32'(m_state != IDLE || inf != 0));
    if (zchk) begin
      chk("reset_o_data", o_data, 32'h0);
      chk("reset_o_valid", 32'(o_valid), 32'h0);
      chk("reset_o_comp_data", 32'(o_comp_data), 32'h0);
    end
    zchk = rst;
    last_hs = i_valid & o_ready;
    exp_cv = g >= 0;
    if (g >= 0) begin
      dd = i_data >> (g*W);
      exp_cd = dd[W-1:0];
      expq[g].push_back('{d: dd[W-1:0] ^ 8'h5A, due: cyc + LAT + 2});
      gcyc.push_back(cyc);
      m_ptr = (g + 1) % NCH;
    end
    if (rst) begin
      m_state = IDLE;
      m_ptr = 0;
      gcyc.delete();
      clr = 1'b1;
    end else begin
      case (m_state)
        IDLE: if (en && i_valid != '0) m_state = RUN;
        RUN: if (!en) m_state = DRAIN;
        default: if (en) m_state = RUN; else if (inf == 0) m_state = IDLE;
      endcase
    end
  endtask
  initial begin
    repeat (3) tick(1, 0, 4'b0000, 0, 0, -1);
    repeat (2) tick(0, 1, 4'b0001, 100, 0, 8'h10);
    repeat (6) tick(0, 1, 4'b0000, 0, 0, -1);
    repeat (12) tick(0, 1, 4'b1111, 100, 0, -1);
    repeat (16) tick(0, 1, 4'b0100, 100, 0, -1);
    repeat (8) tick(0, 0, 4'b0100, 100, 0, -1);
    repeat (6) tick(0, 1, 4'b1111, 100, 0, -1);
    tick(1, 1, 4'b1111, 100, 0, -1);
    repeat (6) tick(0, 1, 4'b0110, 100, 0, -1);
    repeat (60) tick(0, 1, 4'b1111, 50, 1, -1);
    repeat (60) tick(0, $urandom_range(0, 3) != 0, 4'b1111, 60, 1, -1);
    for (int i = 0; i < 40 && !(o_busy === 1'b0 && pending() == 0); i++) tick(0, 0, 4'b0000, 0, 0, -1);
    chk("drain_outstanding", 32'(pending()), 32'h0);
    chk("drain_busy", 32'(o_busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
